// File: rtl/pipelined_mult_fu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipelined_mult_fu_pkg                                           |
// | Purpose  : Shared types for the M-extension multiply FU: issue/CDB         |
// |            payloads, multiply sign modes and the funct3 decode helper.     |
// | Revision : 1.0 - initial pipelined multiply FU                             |
// +----------------------------------------------------------------------------+
package pipelined_mult_fu_pkg;

    localparam int XLEN   = 32;
    localparam int PHYS_W = 6;
    localparam int ROB_W  = 4;

    // Operand signedness for the high-half variants; the decode is shared with
    // any future divider FU.
    typedef enum logic [1:0] {
        SS = 2'd0,
        SU = 2'd1,
        UU = 2'd2
    } mul_sign_t;

    typedef struct packed {
        logic              valid;
        logic [63:0]       order;
        logic [XLEN-1:0]   inst;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [XLEN-1:0]   rs1_rdata;
        logic [XLEN-1:0]   rs2_rdata;
        logic [4:0]        rd_addr;
        logic [XLEN-1:0]   rd_wdata;
        logic [XLEN-1:0]   pc_rdata;
        logic [XLEN-1:0]   pc_wdata;
    } rvfi_data_t;

    typedef struct packed {
        logic [XLEN-1:0]   ps1_v;
        logic [XLEN-1:0]   ps2_v;
        logic [PHYS_W-1:0] pd_s;
        logic [ROB_W-1:0]  rob_num;
        logic [XLEN-1:0]   instr;
        rvfi_data_t        rvfi_data;
    } issue_fu_data_t;

    typedef struct packed {
        logic [PHYS_W-1:0] pd_s;
        logic [XLEN-1:0]   pd_v;
        logic [ROB_W-1:0]  rob_num;
        logic              br_en;
        logic              instr_is_br;
        logic              br_taken;
        logic [XLEN-1:0]   br_target;
        logic [XLEN-1:0]   instr_pc;
        rvfi_data_t        rvfi_data;
    } fu_cdb_data_t;

    typedef struct packed {
        mul_sign_t sign;
        logic      upper;
        logic      legal;
    } mul_dec_t;

    // Metadata travelling alongside the product through the pipeline.
    typedef struct packed {
        logic [PHYS_W-1:0] pd_s;
        logic [ROB_W-1:0]  rob_num;
        logic              upper;
        rvfi_data_t        rvfi_data;
    } mul_meta_t;

    // One completed result waiting for the CDB.
    typedef struct packed {
        logic [PHYS_W-1:0] pd_s;
        logic [ROB_W-1:0]  rob_num;
        logic [XLEN-1:0]   result;
        rvfi_data_t        rvfi_data;
    } mul_q_entry_t;

    // funct3 -> signedness and half select. mul takes the low half, which is
    // identical for any extension, so it reuses SS.
    function automatic mul_dec_t decode_mul(input logic [2:0] funct3);
        mul_dec_t d;
        d.sign  = SS;
        d.upper = 1'b0;
        d.legal = 1'b1;
        case (funct3)
            3'b000: begin d.sign = SS; d.upper = 1'b0; end
            3'b001: begin d.sign = SS; d.upper = 1'b1; end
            3'b010: begin d.sign = SU; d.upper = 1'b1; end
            3'b011: begin d.sign = UU; d.upper = 1'b1; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_mult_fu_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipelined_multiplier                                            |
// | Purpose  : Fixed-latency (OPERAND_WIDTH+1)-bit signed multiplier. Two      |
// |            partial products are formed at the input and carried through   |
// |            STAGES-1 register ranks; the final add feeds the consumer's     |
// |            capture register, which is the STAGES-th clock edge.            |
// | Revision : 1.0 - initial pipelined multiply FU                             |
// +----------------------------------------------------------------------------+
module pipelined_multiplier
    import pipelined_mult_fu_pkg::*;
#(
    parameter int OPERAND_WIDTH = 32,
    parameter int STAGES        = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  mul_sign_t                    sign,
    input  logic [OPERAND_WIDTH-1:0]     a,
    input  logic [OPERAND_WIDTH-1:0]     b,
    output logic                         out_valid,
    output logic [2*OPERAND_WIDTH-1:0]   p
);

    localparam int c_EXT_W = OPERAND_WIDTH + 1;
    localparam int c_LO_W  = (OPERAND_WIDTH + 2) / 2;
    localparam int c_HI_W  = c_EXT_W - c_LO_W;
    localparam int c_PW    = 2 * OPERAND_WIDTH;

    logic signed [c_EXT_W-1:0] w_a_ext;
    logic signed [c_EXT_W-1:0] w_b_ext;
    logic signed [c_LO_W:0]    w_b_lo_s;
    logic signed [c_HI_W-1:0]  w_b_hi_s;
    logic signed [c_PW-1:0]    w_pp_lo;
    logic signed [c_PW-1:0]    w_pp_hi;

    // rs1 is signed for SS and SU, rs2 only for SS.
    assign w_a_ext  = {(sign != UU) & a[OPERAND_WIDTH-1], a};
    assign w_b_ext  = {(sign == SS) & b[OPERAND_WIDTH-1], b};

    // b_ext = b_hi (signed) * 2^LO_W + b_lo (unsigned); the product is kept
    // modulo 2^(2*OPERAND_WIDTH), which is all the consumer ever reads.
    assign w_b_lo_s = {1'b0, w_b_ext[c_LO_W-1:0]};
    assign w_b_hi_s = w_b_ext[c_EXT_W-1:c_LO_W];
    assign w_pp_lo  = c_PW'(w_a_ext) * c_PW'(w_b_lo_s);
    assign w_pp_hi  = c_PW'(w_a_ext) * c_PW'(w_b_hi_s);

    generate
        if (STAGES == 1) begin : g_comb
            assign out_valid = in_valid;
            assign p         = w_pp_lo + (w_pp_hi << c_LO_W);
        end else begin : g_pipe
            localparam int c_RANKS = STAGES - 1;
            logic [c_RANKS-1:0] r_vld;
            logic [c_PW-1:0]    r_pp_lo [c_RANKS];
            logic [c_PW-1:0]    r_pp_hi [c_RANKS];

            // Valid tags shift one rank per cycle and are cleared by reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= in_valid;
                    for (int k = 1; k < c_RANKS; k++) begin
                        r_vld[k] <= r_vld[k-1];
                    end
                end
            end

            // Partial products advance unconditionally; validity lives in r_vld.
            always_ff @(posedge clk) begin
                r_pp_lo[0] <= w_pp_lo;
                r_pp_hi[0] <= w_pp_hi;
                for (int k = 1; k < c_RANKS; k++) begin
                    r_pp_lo[k] <= r_pp_lo[k-1];
                    r_pp_hi[k] <= r_pp_hi[k-1];
                end
            end

            assign out_valid = r_vld[c_RANKS-1];
            assign p         = r_pp_lo[c_RANKS-1] + (r_pp_hi[c_RANKS-1] << c_LO_W);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/pipelined_mult_fu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipelined_mult_fu                                               |
// | Purpose  : Fully pipelined M-extension multiply FU. One op per cycle,      |
// |            PIPE_STAGES latency, in-order results held in an OUT_DEPTH      |
// |            circular queue until the CDB acknowledges them. Credit-based    |
// |            busy guarantees the queue never overflows.                      |
// | Revision : 1.0 - initial pipelined multiply FU                             |
// +----------------------------------------------------------------------------+
module pipelined_mult_fu
    import pipelined_mult_fu_pkg::*;
#(
    parameter int PIPE_STAGES   = 3,
    parameter int OUT_DEPTH     = 4,
    parameter int OPERAND_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           branch_mispredict,
    input  issue_fu_data_t input_data,
    input  logic           fu_start,
    input  logic           cdb_ack,
    output fu_cdb_data_t   output_data,
    output logic           fu_busy,
    output logic           fu_done
);

    localparam int c_PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int c_OCC_W = $clog2(OUT_DEPTH + PIPE_STAGES + 1);

    logic                       w_flush;
    logic                       w_accept;
    logic                       w_push;
    logic                       w_pop;
    mul_dec_t                   w_dec;
    mul_meta_t                  w_in_meta;
    mul_meta_t                  w_tail_meta;
    logic [2*OPERAND_WIDTH-1:0] w_prod;
    logic [XLEN-1:0]            w_result;
    mul_q_entry_t               w_entry;
    logic [c_OCC_W-1:0]         w_pipe_cnt;
    logic [c_OCC_W-1:0]         w_occ;
    logic                       w_unused_instr;

    logic [c_PTR_W-1:0]         r_head;
    logic [c_PTR_W-1:0]         r_tail;
    logic [c_CNT_W-1:0]         r_count;
    mul_q_entry_t               r_q [OUT_DEPTH];

    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_PTR_W'(OUT_DEPTH - 1)) ? '0 : ptr + c_PTR_W'(1);
    endfunction

    // A mispredict is handled exactly like a reset of every piece of state.
    assign w_flush        = rst | branch_mispredict;
    assign w_accept       = fu_start & ~fu_busy;
    assign w_dec          = decode_mul(input_data.instr[14:12]);
    assign w_unused_instr = ^{input_data.instr[31:15], input_data.instr[11:0]};

    // Capture the metadata that must travel with the product.
    always_comb begin
        w_in_meta           = '0;
        w_in_meta.pd_s      = input_data.pd_s;
        w_in_meta.rob_num   = input_data.rob_num;
        w_in_meta.upper     = w_dec.upper;
        w_in_meta.rvfi_data = input_data.rvfi_data;
    end

    pipelined_multiplier #(
        .OPERAND_WIDTH (OPERAND_WIDTH),
        .STAGES        (PIPE_STAGES)
    ) u_mult (
        .clk       (clk),
        .rst       (w_flush),
        .in_valid  (w_accept),
        .sign      (w_dec.sign),
        .a         (input_data.ps1_v),
        .b         (input_data.ps2_v),
        .out_valid (w_push),
        .p         (w_prod)
    );

    generate
        if (PIPE_STAGES == 1) begin : g_meta_comb
            assign w_tail_meta = w_in_meta;
            assign w_pipe_cnt  = '0;
        end else begin : g_meta_pipe
            localparam int c_RANKS = PIPE_STAGES - 1;
            logic [c_RANKS-1:0] r_vld;
            mul_meta_t          r_meta [c_RANKS];

            // Per-rank valid tags; these feed the credit count.
            always_ff @(posedge clk) begin
                if (w_flush) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= w_accept;
                    for (int k = 1; k < c_RANKS; k++) begin
                        r_vld[k] <= r_vld[k-1];
                    end
                end
            end

            // Metadata shifts in lockstep with the multiplier's partial products.
            always_ff @(posedge clk) begin
                r_meta[0] <= w_in_meta;
                for (int k = 1; k < c_RANKS; k++) begin
                    r_meta[k] <= r_meta[k-1];
                end
            end

            // Number of ops still inside the multiplier.
            always_comb begin
                w_pipe_cnt = '0;
                for (int k = 0; k < c_RANKS; k++) begin
                    w_pipe_cnt = w_pipe_cnt + c_OCC_W'(r_vld[k]);
                end
            end

            assign w_tail_meta = r_meta[c_RANKS-1];
        end
    endgenerate

    assign w_result = w_tail_meta.upper ? w_prod[2*OPERAND_WIDTH-1:OPERAND_WIDTH]
                                        : w_prod[OPERAND_WIDTH-1:0];

    // Completed entry as it will be presented to the CDB.
    always_comb begin
        w_entry                    = '0;
        w_entry.pd_s               = w_tail_meta.pd_s;
        w_entry.rob_num            = w_tail_meta.rob_num;
        w_entry.result             = w_result;
        w_entry.rvfi_data          = w_tail_meta.rvfi_data;
        w_entry.rvfi_data.rd_wdata = w_result;
    end

    assign fu_done = (r_count != '0);
    assign w_pop   = cdb_ack & fu_done;
    assign w_occ   = w_pipe_cnt + c_OCC_W'(r_count);
    // Every op in flight already owns a queue slot, so the queue cannot overflow.
    assign fu_busy = (w_occ >= c_OCC_W'(OUT_DEPTH));

    // Queue pointers and count; push and pop in one cycle leave count unchanged.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= f_next(r_tail);
            end
            if (w_pop) begin
                r_head <= f_next(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage; a write during a flush is harmless because count is cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q[r_tail] <= w_entry;
        end
    end

    // Head-of-queue result with the branch fields tied off.
    always_comb begin
        output_data                    = '0;
        output_data.pd_s               = r_q[r_head].pd_s;
        output_data.pd_v               = r_q[r_head].result;
        output_data.rob_num            = r_q[r_head].rob_num;
        output_data.rvfi_data          = r_q[r_head].rvfi_data;
        output_data.rvfi_data.rd_wdata = r_q[r_head].result;
        output_data.br_en              = 1'b0;
        output_data.instr_is_br        = 1'b0;
        output_data.br_taken           = 1'b0;
        output_data.br_target          = '0;
        output_data.instr_pc           = '0;
    end

`ifndef SYNTHESIS
    a_no_start_when_busy : assert property (@(posedge clk) disable iff (w_flush)
        !(fu_start && fu_busy));
    a_legal_funct3 : assert property (@(posedge clk) disable iff (w_flush)
        w_accept |-> w_dec.legal);
    a_queue_space : assert property (@(posedge clk) disable iff (w_flush)
        w_push |-> ((r_count < c_CNT_W'(OUT_DEPTH)) || w_pop));
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_mult_fu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pipelined_mult_fu                                            |
// | Purpose  : Directed-vector bench for pipelined_mult_fu (PIPE_STAGES=3,     |
// |            OUT_DEPTH=4) with hand-computed expected results.               |
// | Revision : 1.0 - initial pipelined multiply FU                             |
// +----------------------------------------------------------------------------+
module tb_pipelined_mult_fu;
    import pipelined_mult_fu_pkg::*;

    localparam logic [2:0] c_F3_MUL    = 3'b000;
    localparam logic [2:0] c_F3_MULH   = 3'b001;
    localparam logic [2:0] c_F3_MULHSU = 3'b010;
    localparam logic [2:0] c_F3_MULHU  = 3'b011;

    logic           clk = 1'b0;
    logic           rst;
    logic           branch_mispredict;
    issue_fu_data_t input_data;
    logic           fu_start;
    logic           cdb_ack;
    fu_cdb_data_t   output_data;
    logic           fu_busy;
    logic           fu_done;

    int n_vec = 0;
    int n_err = 0;

    pipelined_mult_fu #(
        .PIPE_STAGES   (3),
        .OUT_DEPTH     (4),
        .OPERAND_WIDTH (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .branch_mispredict (branch_mispredict),
        .input_data        (input_data),
        .fu_start          (fu_start),
        .cdb_ack           (cdb_ack),
        .output_data       (output_data),
        .fu_busy           (fu_busy),
        .fu_done           (fu_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] rob);
        input_data                    = '0;
        input_data.ps1_v              = a;
        input_data.ps2_v              = b;
        input_data.rob_num            = rob;
        input_data.pd_s               = {2'b01, rob};
        input_data.instr              = {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
        input_data.rvfi_data.rd_addr  = 5'd3;
        input_data.rvfi_data.order    = 64'(rob);
        fu_start                      = 1'b1;
    endtask

    // Single op from an empty FU: issue in cycle 0, result visible in cycle 3.
    task automatic run_one(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] rob,
                           input logic [31:0] exp);
        issue(f3, a, b, rob);
        step();
        fu_start = 1'b0;
        check({tag, "_done_c1"}, 64'(fu_done), 64'd0);
        step();
        check({tag, "_done_c2"}, 64'(fu_done), 64'd0);
        step();
        check({tag, "_done_c3"}, 64'(fu_done), 64'd1);
        check({tag, "_pd_v"}, 64'(output_data.pd_v), 64'(exp));
        check({tag, "_rd_wdata"}, 64'(output_data.rvfi_data.rd_wdata), 64'(exp));
        check({tag, "_rob"}, 64'(output_data.rob_num), 64'(rob));
        check({tag, "_pd_s"}, 64'(output_data.pd_s), 64'({2'b01, rob}));
        check({tag, "_br"}, 64'({output_data.br_en, output_data.instr_is_br,
                                 output_data.br_taken}), 64'd0);
        cdb_ack = 1'b1;
        step();
        cdb_ack = 1'b0;
        check({tag, "_done_after_ack"}, 64'(fu_done), 64'd0);
    endtask

    initial begin
        rst               = 1'b1;
        branch_mispredict = 1'b0;
        fu_start          = 1'b0;
        cdb_ack           = 1'b0;
        input_data        = '0;
        step();
        step();
        rst = 1'b0;
        check("reset_busy", 64'(fu_busy), 64'd0);
        check("reset_done", 64'(fu_done), 64'd0);

        // Ack on an empty queue must be ignored.
        cdb_ack = 1'b1;
        step();
        cdb_ack = 1'b0;
        check("idle_ack_done", 64'(fu_done), 64'd0);
        check("idle_ack_busy", 64'(fu_busy), 64'd0);

        // Arithmetic variants.
        run_one("mul_m1x2", c_F3_MUL, 32'hFFFFFFFF, 32'h00000002, 4'd1, 32'hFFFFFFFE);
        run_one("mulh_m1", c_F3_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2, 32'h00000000);
        run_one("mulhsu_m1", c_F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3, 32'hFFFFFFFF);
        run_one("mulhu_m1", c_F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd4, 32'hFFFFFFFE);
        run_one("mulh_min", c_F3_MULH, 32'h80000000, 32'h80000000, 4'd5, 32'h40000000);
        run_one("mulhu_small", c_F3_MULHU, 32'h12345678, 32'h00000010, 4'd6, 32'h00000001);

        // Four back-to-back issues without ack: credit exhausts, then drains in order.
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) check("burst_busy_before4", 64'(fu_busy), 64'd0);
            issue(c_F3_MUL, 32'(i), 32'd3, 4'(i));
            step();
        end
        fu_start = 1'b0;
        check("burst_busy_after4", 64'(fu_busy), 64'd1);
        step();
        step();
        check("burst_done", 64'(fu_done), 64'd1);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("burst_rob%0d", k), 64'(output_data.rob_num), 64'(k));
            check($sformatf("burst_val%0d", k), 64'(output_data.pd_v), 64'(3 * k));
            cdb_ack = 1'b1;
            step();
            if (k == 1) check("burst_busy_after_ack", 64'(fu_busy), 64'd0);
        end
        cdb_ack = 1'b0;
        check("burst_drained", 64'(fu_done), 64'd0);

        // Queue at 3 entries: ack coincides with the next result write (pointers wrap).
        for (int i = 5; i <= 8; i++) begin
            issue(c_F3_MUL, 32'(i), 32'd5, 4'(i));
            step();
        end
        fu_start = 1'b0;
        step();
        check("pp_busy_full", 64'(fu_busy), 64'd1);
        check("pp_head5", 64'(output_data.rob_num), 64'd5);
        cdb_ack = 1'b1;
        step();
        check("pp_busy_after", 64'(fu_busy), 64'd0);
        for (int k = 6; k <= 8; k++) begin
            check($sformatf("pp_rob%0d", k), 64'(output_data.rob_num), 64'(k));
            check($sformatf("pp_val%0d", k), 64'(output_data.pd_v), 64'(5 * k));
            step();
        end
        cdb_ack = 1'b0;
        check("pp_drained", 64'(fu_done), 64'd0);

        // Flush with two ops in flight and one queued, alongside a start and an ack.
        for (int i = 9; i <= 11; i++) begin
            issue(c_F3_MUL, 32'(i), 32'd2, 4'(i));
            step();
        end
        check("fl_head9", 64'(output_data.rob_num), 64'd9);
        issue(c_F3_MUL, 32'd12, 32'd2, 4'd12);
        cdb_ack           = 1'b1;
        branch_mispredict = 1'b1;
        step();
        fu_start          = 1'b0;
        cdb_ack           = 1'b0;
        branch_mispredict = 1'b0;
        check("fl_done", 64'(fu_done), 64'd0);
        check("fl_busy", 64'(fu_busy), 64'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("fl_stale_c%0d", c), 64'(fu_done), 64'd0);
        end
        run_one("fl_fresh_7x6", c_F3_MUL, 32'd7, 32'd6, 4'd13, 32'd42);

        // Reset one cycle after a start: the op must never surface.
        issue(c_F3_MUL, 32'd9, 32'd9, 4'd14);
        step();
        fu_start = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        check("rst_done", 64'(fu_done), 64'd0);
        check("rst_busy", 64'(fu_busy), 64'd0);
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("rst_stale_c%0d", c), 64'(fu_done), 64'd0);
        end
        run_one("rst_fresh_mulhsu", c_F3_MULHSU, 32'h80000000, 32'h00000002, 4'd15,
                32'hFFFFFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
